// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue
// ----------------------------------------------------------------------------
// Instruction fetch front end. It issues sequential requests to a
// single-cycle-latency instruction RAM and buffers the returned words in a
// small FIFO that feeds decode with a valid/ready handshake. A redirect from
// execute flushes the FIFO and restarts fetch at a new, aligned address. A
// halt stops new requests, but a response already in flight is still queued.
//
// Ports
//   clk          in   1        clock, all state on the rising edge
//   rst          in   1        asynchronous active-low reset (0 = reset)
//   mem_en       out  1        fetch request to the instruction RAM
//   mem_addr     out  ADDR_W   byte address of the request (current pc)
//   mem_rdata    in   INSTR_W  RAM read data, valid one cycle after mem_en
//   redirect     in   1        flush the queue and restart fetch
//   redirect_pc  in   ADDR_W   restart address, low bits are forced to 0
//   halt         in   1        suppress new requests
//   instr_valid  out  1        head entry valid toward decode
//   instr        out  INSTR_W  head instruction
//   instr_pc     out  ADDR_W   address of the head instruction
//   instr_ready  in   1        decode accepts the head this cycle
//   count        out  CNT_W    number of occupied queue entries
// ============================================================================
module fetch_queue #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter int unsigned        DEPTH    = 4,   // power of two, >= 2
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [INSTR_W-1:0]        mem_rdata,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    input  logic                      halt,
    output logic                      instr_valid,
    output logic [INSTR_W-1:0]        instr,
    output logic [ADDR_W-1:0]         instr_pc,
    input  logic                      instr_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned STEP_BYTES = INSTR_W / 8;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(STEP_BYTES);
    // Clears the byte-offset bits inside one instruction word.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP_BYTES - 1));

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]  pc_q;         // next address to request
    logic               inflight_q;   // a RAM response arrives this cycle
    logic [ADDR_W-1:0]  issue_pc_q;   // address of the in-flight request
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [INSTR_W-1:0] word_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     occupancy;
    logic [CNT_W:0]     limit;

    assign instr_valid = (count_q != '0);

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pop       = 1'b0;
        push      = 1'b0;
        issue     = 1'b0;
        occupancy = '0;
        limit     = '0;

        if (rst && !redirect) begin
            pop  = instr_valid && instr_ready;
            push = inflight_q;

            // Entries already held plus the one on its way back must leave
            // room for a new word; a pop this cycle frees one slot early.
            occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
            limit     = (CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(pop);
            issue     = !halt && (occupancy < limit);
        end
    end

    // ------------------------------------------------------------------------
    // Fetch pointer, in-flight tracking and queue bookkeeping
    // ------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            issue_pc_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else if (redirect) begin
            // Nothing is issued in the redirect cycle, and clearing the
            // in-flight bit drops the response arriving right now.
            pc_q       <= redirect_pc & ALIGN_MASK;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q       <= pc_q + PC_STEP;
                issue_pc_q <= pc_q;
            end
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only visible once it
    // has been written and counted, so its power-up contents never matter.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= issue_pc_q;
            word_mem[tail_q] <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The head is read straight from registered storage; gating with
    // instr_valid makes instr/instr_pc read zero while the queue is empty.
    assign instr    = instr_valid ? word_mem[head_q] : '0;
    assign instr_pc = instr_valid ? pc_mem[head_q]   : '0;
    assign mem_en   = issue;
    assign mem_addr = pc_q;
    assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue
// ----------------------------------------------------------------------------
// Self-checking bench for fetch_queue with default parameters. A behavioural
// model holds the queue as a list of {pc, word} entries plus one pending
// request, and predicts outputs every cycle. The instruction RAM returns the
// word index (address / 4) for each requested address. Directed scenarios
// (streaming, backpressure, redirect, wrap, halt, async reset) are followed
// by a randomized phase.
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  count;

    fetch_queue #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      mq[$];
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pc;

    // Values observed at the last check point, used by directed checks
    logic        obs_en;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_instr;
    logic [2:0]  obs_count;

    logic [31:0] ram_next;
    int          n_issue;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_pc      = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"},   64'(mem_en),      64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr),    64'h0);
        check({tag, "_count"},    64'(count),       64'd0);
        check({tag, "_valid"},    64'(instr_valid), 64'd0);
        check({tag, "_instr"},    64'(instr),       64'd0);
        check({tag, "_instr_pc"}, 64'(instr_pc),    64'h0);
    endtask

    // One clock cycle. Entered just after a rising edge with inputs already
    // applied; checks outputs mid-cycle, then advances model and RAM.
    task automatic cycle();
        logic pop;
        logic issue;
        #2;
        obs_en    = mem_en;
        obs_addr  = mem_addr;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        obs_instr = instr;
        obs_count = count;
        pop   = 1'b0;
        issue = 1'b0;
        if (!rst) begin
            check_reset_outputs("in_reset");
        end else begin
            pop   = (mq.size() != 0) && instr_ready && !redirect;
            issue = !redirect && !halt &&
                    (mq.size() + int'(m_pend) < DEPTH + int'(pop));
            check("valid",    64'(instr_valid), 64'(mq.size() != 0));
            check("count",    64'(count),       64'(mq.size()));
            check("mem_en",   64'(mem_en),      64'(issue));
            check("mem_addr", 64'(mem_addr),    64'(m_pc));
            if (mq.size() != 0) begin
                check("instr",    64'(instr),    64'(mq[0].data));
                check("instr_pc", 64'(instr_pc), 64'(mq[0].pc));
            end
        end
        // RAM: real data one cycle after a request, garbage otherwise
        ram_next = (rst && mem_en) ? word_of(mem_addr) : $urandom;

        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (redirect) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = redirect_pc & ~32'h3;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back('{pc: m_pend_pc, data: word_of(m_pend_pc)});
            m_pend = issue;
            if (issue) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
        #1;
        mem_rdata = ram_next;
    endtask

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        instr_ready = 1'b0;
        mem_rdata   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Streaming: one issue per cycle, head valid from cycle 2
        rst         = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("stream_en",   64'(obs_en),   64'd1);
            check("stream_addr", 64'(obs_addr), 64'(4 * k));
            if (k < 2) begin
                check("stream_valid_early", 64'(obs_valid), 64'd0);
            end else begin
                check("stream_valid", 64'(obs_valid), 64'd1);
                check("stream_pc",    64'(obs_pc),    64'(4 * (k - 2)));
                check("stream_instr", 64'(obs_instr), 64'(k - 2));
            end
        end

        // Backpressure: restart at 0 with decode stalled
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        cycle();
        redirect = 1'b0;
        n_issue  = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_en) begin
                check("bp_addr", 64'(obs_addr), 64'(4 * n_issue));
                n_issue++;
            end
        end
        check("bp_issues", 64'(n_issue),   64'd4);
        check("bp_count",  64'(obs_count), 64'd4);
        check("bp_en_off", 64'(obs_en),    64'd0);
        instr_ready = 1'b1;
        cycle();
        check("bp_resume_en",   64'(obs_en),    64'd1);
        check("bp_resume_addr", 64'(obs_addr),  64'h10);
        check("bp_resume_pop",  64'(obs_valid), 64'd1);

        // Redirect with a full queue and a request in flight
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        cycle();
        check("redir_no_issue", 64'(obs_en), 64'd0);
        redirect = 1'b0;
        cycle();
        check("redir_count", 64'(obs_count), 64'd0);
        check("redir_valid", 64'(obs_valid), 64'd0);
        check("redir_en",    64'(obs_en),    64'd1);
        check("redir_addr",  64'(obs_addr),  64'h100);
        cycle();
        check("redir_valid_gap", 64'(obs_valid), 64'd0);
        cycle();
        check("redir_first_valid", 64'(obs_valid), 64'd1);
        check("redir_first_pc",    64'(obs_pc),    64'h100);
        check("redir_first_instr", 64'(obs_instr), 64'h40);

        // Address wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k == 2) check("wrap_pc0", 64'(obs_pc), 64'hFFFF_FFF8);
            if (k == 3) check("wrap_pc1", 64'(obs_pc), 64'hFFFF_FFFC);
            if (k == 4) begin
                check("wrap_pc2",    64'(obs_pc),    64'h0);
                check("wrap_instr2", 64'(obs_instr), 64'h0);
            end
        end

        // Halt for 5 cycles with word 0xC in flight; decode stalled
        halt        = 1'b1;
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("halt_no_en", 64'(obs_en), 64'd0);
        end
        check("halt_count", 64'(obs_count), 64'd2);
        check("halt_head",  64'(obs_pc),    64'h8);
        halt        = 1'b0;
        instr_ready = 1'b1;
        cycle();
        check("halt_resume_en",   64'(obs_en),   64'd1);
        check("halt_resume_addr", 64'(obs_addr), 64'h10);
        cycle();
        check("halt_kept_pc",    64'(obs_pc),    64'hC);
        check("halt_kept_instr", 64'(obs_instr), 64'h3);

        // Asynchronous reset between edges
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
        rst = 1'b1;
        cycle();
        check("async_first_en",   64'(obs_en),   64'd1);
        check("async_first_addr", 64'(obs_addr), 64'h0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst         = ($urandom_range(0, 59) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            halt        = ($urandom_range(0, 7) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
